// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: opcode constants, the fetch NOP and the boot-loader state encoding.
// No logic; constants and types only.
// Imported by the fetch stage and the control unit.
package riscv_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_J     = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LW    = 7'b0000011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        LD_CNT0 = 2'd0,
        LD_CNT1 = 2'd1,
        LD_DATA = 2'd2,
        RUN     = 2'd3
    } ld_state_t;

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: one synchronous write port, one asynchronous read port, 2^ADDR_W x 32.
// Read latency zero; write lands on the clock edge.
// No backpressure; contents are not cleared by reset.
module instr_mem #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_loader.sv
// Fetch stage: PC register, instruction memory and UART boot loader that fills memory before releasing the core.
// instr is a zero-latency read of mem[pc] in RUN; PC advances every edge in RUN.
// No backpressure: bytes are taken only on rx_valid strobes and cannot be stalled.
module instr_fetch_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] instr,
    output logic [6:0]  opCode,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        core_en,
    output logic        load_done,
    output logic        load_err
);

    import riscv_pkg::*;

    localparam logic [16:0] DEPTH = 17'(1 << ADDR_W);

    ld_state_t   state, state_nxt;
    logic [15:0] cnt;
    logic [15:0] word_ctr;
    logic [16:0] word_ctr_inc;
    logic [1:0]  byte_idx;
    logic [23:0] byte_buf;
    logic        enter_run, word_done, mem_we, ovf, misalign;
    logic [31:0] mem_rdata;

    assign word_ctr_inc = {1'b0, word_ctr} + 17'd1;

    always_ff @(posedge clk) begin
        if (rst) state <= LD_CNT0;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        enter_run = 1'b0;
        word_done = 1'b0;
        mem_we    = 1'b0;
        ovf       = 1'b0;
        case (state)
            LD_CNT0: if (rx_valid) state_nxt = LD_CNT1;
            LD_CNT1: begin
                if (rx_valid) begin
                    if ({rx_data, cnt[7:0]} == 16'd0) begin
                        state_nxt = RUN;
                        enter_run = 1'b1;
                    end else begin
                        state_nxt = LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                if (rx_valid && byte_idx == 2'd3) begin
                    word_done = 1'b1;
                    // Words past the end of memory are dropped but still counted.
                    if ({1'b0, word_ctr} < DEPTH) mem_we = 1'b1;
                    else                          ovf    = 1'b1;
                    if (word_ctr_inc == {1'b0, cnt}) begin
                        state_nxt = RUN;
                        enter_run = 1'b1;
                    end
                end
            end
            RUN:     state_nxt = RUN;
            default: state_nxt = LD_CNT0;
        endcase
    end

    // Misalignment is only meaningful while the core is executing.
    assign misalign = (state == RUN) && branch_taken && (branch_target[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            cnt       <= 16'd0;
            word_ctr  <= 16'd0;
            byte_idx  <= 2'd0;
            byte_buf  <= 24'd0;
        end else begin
            load_done <= enter_run;
            if (ovf || misalign) load_err <= 1'b1;

            if (state == LD_CNT0 && rx_valid) cnt[7:0]  <= rx_data;
            if (state == LD_CNT1 && rx_valid) cnt[15:8] <= rx_data;

            if (state == LD_DATA && rx_valid) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0:    byte_buf[7:0]   <= rx_data;
                    2'd1:    byte_buf[15:8]  <= rx_data;
                    2'd2:    byte_buf[23:16] <= rx_data;
                    default: ;
                endcase
            end
            if (word_done) word_ctr <= word_ctr_inc[15:0];

            if (enter_run)          pc <= RESET_PC;
            else if (state == RUN)  pc <= branch_taken ? {branch_target[31:2], 2'b00} : pc_plus4;
        end
    end

    instr_mem #(.ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (word_ctr[ADDR_W-1:0]),
        .wdata ({rx_data, byte_buf}),
        .raddr (pc[ADDR_W+1:2]),
        .rdata (mem_rdata)
    );

    assign pc_plus4 = pc + 32'd4;
    assign core_en  = (state == RUN);
    assign instr    = (state == RUN) ? mem_rdata : NOP_INSTR;
    assign opCode   = instr[6:0];

endmodule

// File: tb/tb_instr_fetch_loader.sv
// Bench for instr_fetch_loader: a default-depth instance and a 4-word instance for overflow.
module tb_instr_fetch_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_valid = 1'b0, rx_valid2 = 1'b0;
    logic [7:0]  rx_data = 8'h00, rx_data2 = 8'h00;
    logic        branch_taken = 1'b0, branch_taken2 = 1'b0;
    logic [31:0] branch_target = 32'h0, branch_target2 = 32'h0;
    logic [31:0] instr, pc, pc_plus4, instr2, pc2, pc_plus4_2;
    logic [6:0]  opCode, opCode2;
    logic        core_en, load_done, load_err, core_en2, load_done2, load_err2;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ins_q[$];

    always #5 clk = ~clk;

    instr_fetch_loader dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .instr(instr), .opCode(opCode), .pc(pc), .pc_plus4(pc_plus4),
        .core_en(core_en), .load_done(load_done), .load_err(load_err)
    );

    instr_fetch_loader #(.ADDR_W(2)) dut2 (
        .clk(clk), .rst(rst), .rx_valid(rx_valid2), .rx_data(rx_data2),
        .branch_taken(branch_taken2), .branch_target(branch_target2),
        .instr(instr2), .opCode(opCode2), .pc(pc2), .pc_plus4(pc_plus4_2),
        .core_en(core_en2), .load_done(load_done2), .load_err(load_err2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sel, input logic [7:0] b);
        if (!sel) begin rx_valid = 1'b1; rx_data = b; end
        else      begin rx_valid2 = 1'b1; rx_data2 = b; end
        tick();
        rx_valid  = 1'b0;
        rx_valid2 = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL reset_core_en: got %b want 0", core_en); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done: got %b want 0", load_done); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err: got %b want 0", load_err); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 00000000", pc); end
        checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4: got %h want 00000004", pc_plus4); end
        checks++; if (instr !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr: got %h want 00000013", instr); end
        checks++; if (opCode !== 7'b0010011) begin errors++; $display("FAIL reset_opcode: got %b want 0010011", opCode); end
        rst = 1'b0;
    endtask

    task automatic test_load();
        logic [7:0] bl [10];
        bl = '{8'h02, 8'h00, 8'h33, 8'h05, 8'hB5, 8'h00, 8'h63, 8'h04, 8'h00, 8'h00};
        for (int i = 0; i < 9; i++) send(1'b0, bl[i]);
        checks++; if (core_en !== 1'b0 || load_done !== 1'b0) begin
            errors++; $display("FAIL load_early_run: core_en=%b load_done=%b want 0 0", core_en, load_done); end
        send(1'b0, bl[9]);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL load_done_pulse: got %b want 1", load_done); end
        checks++; if (core_en !== 1'b1) begin errors++; $display("FAIL load_core_en: got %b want 1", core_en); end
        checks++; if (opCode !== 7'b0110011) begin errors++; $display("FAIL load_opcode: got %b want 0110011", opCode); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL load_err_clean: got %b want 0", load_err); end
        exp_q = {};
        ins_q = {};
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(4 * i));
        ins_q.push_back(32'h00B5_0533);
        ins_q.push_back(32'h0000_0463);
    endtask

    task automatic test_free_run();
        logic [31:0] e;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            e = exp_q.pop_front();
            checks++; if (pc !== e) begin errors++; $display("FAIL run_pc[%0d]: got %h want %h", i, pc, e); end
            checks++; if (pc_plus4 !== e + 32'd4) begin errors++; $display("FAIL run_pc_plus4[%0d]: got %h want %h", i, pc_plus4, e + 32'd4); end
            if (ins_q.size() > 0) begin
                e = ins_q.pop_front();
                checks++; if (instr !== e) begin errors++; $display("FAIL run_instr[%0d]: got %h want %h", i, instr, e); end
            end
            if (i == 1) begin
                checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL load_done_width: got %b want 0", load_done); end
            end
        end
    endtask

    task automatic test_branch();
        branch_taken = 1'b1; branch_target = 32'h0000_0010;
        tick();
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL br_pc: got %h want 00000010", pc); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL br_err_aligned: got %b want 0", load_err); end
        branch_target = 32'h0000_0012;
        tick();
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL br_mis_pc: got %h want 00000010", pc); end
        checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL br_mis_err: got %b want 1", load_err); end
        branch_target = 32'hFFFF_FFFC;
        tick();
        checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL br_top_pc: got %h want fffffffc", pc); end
        checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL br_top_plus4: got %h want 00000000", pc_plus4); end
        branch_taken = 1'b0;
        tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL pc_wrap: got %h want 00000000", pc); end
        send(1'b0, 8'h55);
        checks++; if (pc !== 32'h4 || core_en !== 1'b1) begin
            errors++; $display("FAIL rx_in_run: pc=%h core_en=%b want 00000004 1", pc, core_en); end
    endtask

    task automatic test_zero_count();
        do_reset();
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL zc_err_cleared: got %b want 0", load_err); end
        send(1'b0, 8'h00);
        checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL zc_early: got %b want 0", core_en); end
        send(1'b0, 8'h00);
        checks++; if (core_en !== 1'b1 || load_done !== 1'b1 || pc !== 32'h0) begin
            errors++; $display("FAIL zc_run: core_en=%b load_done=%b pc=%h want 1 1 00000000", core_en, load_done, pc); end
        tick();
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL zc_pulse_end: got %b want 0", load_done); end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] ab [7];
        logic [7:0] fb [6];
        ab = '{8'h04, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        fb = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00};
        do_reset();
        for (int i = 0; i < 7; i++) send(1'b0, ab[i]);
        rst = 1'b1;
        tick();
        checks++; if (core_en !== 1'b0 || instr !== 32'h0000_0013) begin
            errors++; $display("FAIL mid_rst: core_en=%b instr=%h want 0 00000013", core_en, instr); end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) send(1'b0, fb[i]);
        checks++; if (core_en !== 1'b1 || load_done !== 1'b1) begin
            errors++; $display("FAIL mid_reload_run: core_en=%b load_done=%b want 1 1", core_en, load_done); end
        checks++; if (instr !== 32'h0010_0513) begin errors++; $display("FAIL mid_reload_instr: got %h want 00100513", instr); end
        checks++; if (opCode !== 7'b0010011) begin errors++; $display("FAIL mid_reload_opcode: got %b want 0010011", opCode); end
    endtask

    task automatic test_overflow();
        logic [31:0] word, e;
        do_reset();
        exp_q = {};
        send(1'b1, 8'h05);
        send(1'b1, 8'h00);
        for (int w = 0; w < 5; w++) begin
            word = 32'hC0DE_0000 + 32'(w);
            if (w < 4) exp_q.push_back(word);
            for (int k = 0; k < 4; k++) begin
                if (w == 4 && k == 3) begin
                    checks++; if (core_en2 !== 1'b0) begin errors++; $display("FAIL ovf_early_run: got %b want 0", core_en2); end
                end
                send(1'b1, word[8*k +: 8]);
            end
            if (w == 3) begin
                checks++; if (load_err2 !== 1'b0) begin errors++; $display("FAIL ovf_err_early: got %b want 0", load_err2); end
            end
        end
        checks++; if (core_en2 !== 1'b1 || load_done2 !== 1'b1) begin
            errors++; $display("FAIL ovf_run: core_en=%b load_done=%b want 1 1", core_en2, load_done2); end
        checks++; if (load_err2 !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b want 1", load_err2); end
        exp_q.push_back(32'hC0DE_0000);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            e = exp_q.pop_front();
            checks++; if (instr2 !== e) begin errors++; $display("FAIL ovf_mem[%0d]: got %h want %h", i, instr2, e); end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_free_run();
        test_branch();
        test_zero_count();
        test_reset_mid_load();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
